// File: rtl/track_pkg.sv
// Shared definitions for the track sensor conditioning slice.
package track_pkg;

  // Number of track-occupancy sensor lines handled by the conditioner.
  localparam int unsigned NUM_SENSORS = 4;

  // Default debounce and stuck-detection lengths, in Clock cycles.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned STUCK_CYCLES_DEF    = 4096;

  // Default counter widths sized to hold the defaults above.
  localparam int unsigned DB_W_DEF  = 8;
  localparam int unsigned STK_W_DEF = 13;

  // One-hot per-channel qualification states.
  typedef enum logic [3:0] {
    ST_CLEAR    = 4'b0001,
    ST_QUAL_ON  = 4'b0010,
    ST_ACTIVE   = 4'b0100,
    ST_QUAL_OFF = 4'b1000
  } chan_state_t;

endpackage : track_pkg

// File: rtl/sensor_channel.sv
// One track sensor line: two-flop synchronizer, debounce state machine,
// occupancy level/arrival strobe and sticky stuck-occupied flag.
module sensor_channel
  import track_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DB_W            = DB_W_DEF,
  parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF,
  parameter int unsigned STK_W           = STK_W_DEF
) (
  input  logic Clock,
  input  logic RESET,
  input  logic raw,
  input  logic stuck_clr,
  output logic sr,
  output logic sr_rise,
  output logic stuck
);

  // Last count value before a qualification completes.
  localparam logic [DB_W-1:0]  CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  CNT_ONE  = DB_W'(1);
  // Stuck counter saturation point and the value one step before it.
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STUCK_CYCLES);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);

  logic             sync_d;
  logic             sync_q;
  chan_state_t      state;
  logic [DB_W-1:0]  cnt;
  logic [STK_W-1:0] stk_cnt;

  // Bring the asynchronous sensor line into the Clock domain.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_d <= raw;
      sync_q <= sync_d;
    end
  end

  // Debounce FSM; sr/sr_rise/stuck are updated on the same edge as the state
  // so the level follows the qualified state with no extra cycle of latency.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      state   <= ST_CLEAR;
      cnt     <= '0;
      stk_cnt <= '0;
      sr      <= 1'b0;
      sr_rise <= 1'b0;
      stuck   <= 1'b0;
    end else begin
      sr_rise <= 1'b0;
      // Operator clear; a fresh set later in this block overrides it.
      if (stuck_clr) begin
        stuck <= 1'b0;
      end

      case (state)
        ST_CLEAR: begin
          if (sync_q) begin
            state <= ST_QUAL_ON;
            cnt   <= CNT_ONE;
          end
        end

        ST_QUAL_ON: begin
          if (!sync_q) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_ACTIVE;
            cnt     <= '0;
            stk_cnt <= '0;
            sr      <= 1'b1;
            sr_rise <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_ACTIVE: begin
          if (!sync_q) begin
            state <= ST_QUAL_OFF;
            cnt   <= CNT_ONE;
          end else if (stk_cnt != STK_MAX) begin
            stk_cnt <= stk_cnt + STK_ONE;
            if (stk_cnt == STK_LAST) begin
              stuck <= 1'b1;
            end
          end
        end

        ST_QUAL_OFF: begin
          // A short dropout returns to ACTIVE keeping the occupancy age.
          if (sync_q) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            sr    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
          sr    <= 1'b0;
        end
      endcase
    end
  end

endmodule : sensor_channel

// File: rtl/track_sensor_conditioner.sv
// Conditions the raw track-occupancy sensor lines into clean debounced
// levels, arrival strobes and stuck-occupied flags, one channel per line.
module track_sensor_conditioner
  import track_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DB_W            = DB_W_DEF,
  parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF,
  parameter int unsigned STK_W           = STK_W_DEF
) (
  input  logic                   Clock,
  input  logic                   RESET,
  input  logic [NUM_SENSORS:1]   RAW,
  input  logic                   STUCK_CLR,
  output logic [NUM_SENSORS:1]   SR,
  output logic [NUM_SENSORS:1]   SR_RISE,
  output logic [NUM_SENSORS:1]   STUCK
);

  // The single operator clear applies to every channel.
  logic [NUM_SENSORS:1] stuck_clr_fan;
  assign stuck_clr_fan = {NUM_SENSORS{STUCK_CLR}};

  // Independent, identical channel per sensor line.
  for (genvar i = 1; i <= NUM_SENSORS; i++) begin : g_chan
    sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W),
      .STUCK_CYCLES    (STUCK_CYCLES),
      .STK_W           (STK_W)
    ) u_chan (
      .Clock     (Clock),
      .RESET     (RESET),
      .raw       (RAW[i]),
      .stuck_clr (stuck_clr_fan[i]),
      .sr        (SR[i]),
      .sr_rise   (SR_RISE[i]),
      .stuck     (STUCK[i])
    );
  end

endmodule : track_sensor_conditioner

// File: doc/track_sensor_conditioner.md
Name: track_sensor_conditioner

Overview:
- Upstream stage of the two-train track-sharing controller.
- Takes the four raw, bouncy, asynchronous track-occupancy sensor lines and produces clean, synchronous, debounced SR[4:1] levels for the controller.
- Also produces one-cycle arrival strobes and sticky "sensor stuck occupied" fault flags for the operator panel.
- Four identical, independent channels.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive agreeing synchronized samples required to change the SR level (legal range 2..255).
- DB_W, 8: width of the debounce counter. Must hold DEBOUNCE_CYCLES.
- STUCK_CYCLES, 4096: consecutive cycles a channel may stay ACTIVE before its STUCK flag sets (minimum 1).
- STK_W, 13: width of the stuck counter. Must hold STUCK_CYCLES.

Ports:
- Clock, input, 1: system clock. All state updates on the rising edge.
- RESET, input, 1: reset, synchronous, active-high.
- RAW, input, [4:1]: raw sensor lines, asynchronous to Clock, 1 = train present.
- STUCK_CLR, input, 1: synchronous pulse that clears all STUCK flags.
- SR, output, [4:1]: debounced occupancy level. Feeds the controller's SR input.
- SR_RISE, output, [4:1]: one-cycle pulse, asserted in the same cycle SR[i] goes 0 to 1.
- STUCK, output, [4:1]: sticky fault flag, 1 = channel held ACTIVE for at least STUCK_CYCLES.

Behaviour:
- Reset: synchronous. While RESET=1 at an edge, every channel is forced as follows.
  - Sync flops = 0.
  - State = CLEAR.
  - Debounce and stuck counters = 0.
  - SR = 0, SR_RISE = 0, STUCK = 0.
  - A reset asserted mid-qualification or mid-occupancy abandons that activity with no residual state.
- Synchronizer: two-flop chain per channel; sync_q is the second flop. Nothing else samples RAW directly.
- Per-channel one-hot state machine, 4 states:
  - CLEAR (SR=0):
    - sync_q=1 → QUAL_ON, cnt=1.
    - Otherwise stay in CLEAR.
  - QUAL_ON (SR=0):
    - sync_q=0 → CLEAR, cnt=0.
    - sync_q=1 and cnt=DEBOUNCE_CYCLES-1 → ACTIVE, SR_RISE=1 for that cycle, stuck counter=0.
    - Otherwise cnt+1.
  - ACTIVE (SR=1):
    - sync_q=0 → QUAL_OFF, cnt=1.
    - Otherwise the stuck counter increments, saturating at STUCK_CYCLES.
  - QUAL_OFF (SR=1):
    - sync_q=1 → ACTIVE, cnt=0. The stuck counter is retained, not cleared.
    - sync_q=0 and cnt=DEBOUNCE_CYCLES-1 → CLEAR, SR falls.
    - Otherwise cnt+1.
- SR, SR_RISE and STUCK are registered outputs decoded from state.
- Latency: RAW stable from before edge k → sync_q=1 after edge k+1 → SR=1 after edge k+DEBOUNCE_CYCLES+1. The falling edge has the same latency.
- Glitches: any sync_q pulse shorter than DEBOUNCE_CYCLES produces no SR change and no SR_RISE.
- STUCK[i]:
  - Sets on the edge at which the stuck counter reaches STUCK_CYCLES.
  - Stays set until STUCK_CLR=1 or RESET.
  - A new set and STUCK_CLR in the same cycle → set wins.
  - STUCK does not force SR. SR stays 1, so the controller treats the track as occupied (fail-safe).
- Channels are fully independent. Simultaneous activity on all four channels is legal and is processed in parallel with identical timing.
- Counters never wrap. The debounce counter is bounded by the state machine; the stuck counter saturates.

Decomposition:
- Shared package track_pkg holds:
  - One-hot state encodings: CLEAR=4'b0001, QUAL_ON=4'b0010, ACTIVE=4'b0100, QUAL_OFF=4'b1000.
  - Default DEBOUNCE_CYCLES and STUCK_CYCLES constants.
  - NUM_SENSORS=4.
- One sub-module, sensor_channel: synchronizer, state machine and both counters for a single line, instantiated 4 times by track_sensor_conditioner.
- The top level contains only the instantiations and the STUCK_CLR fan-out.

Test Plan (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20):
- Clean rise: RESET 2 cycles, then RAW[1]=1 before edge 0 and held.
  - Required: SR[1]=1 and SR_RISE[1]=1 after edge 5.
  - SR_RISE[1]=0 after edge 6.
  - SR[2..4]=0 throughout.
- Bounce rejection: RAW[2] toggles 1,1,0,1,1,1,0 in consecutive cycles.
  - Required: SR[2] stays 0 and no SR_RISE pulse.
  - Then RAW[2] held at 1: SR[2]=1 exactly 4+1 edges after the last 0 reaches sync_q.
- Release with dropout: SR[3]=1, then RAW[3]=0 for 2 cycles, back to 1, then 0 held.
  - Required: SR[3] stays 1 through the dropout.
  - SR[3] falls 5 edges after the final fall.
  - No second SR_RISE.
- Stuck fault: RAW[4] held at 1.
  - Required: STUCK[4]=1 20 edges after SR[4] rises; SR[4] still 1.
  - STUCK_CLR pulse while RAW[4] is still 1 → STUCK[4]=0 then stays 0, because the counter is saturated and not re-armed until ACTIVE is re-entered from CLEAR or QUAL_ON.
- Reset mid-operation: RAW[1..4]=1, assert RESET at the edge where SR would rise.
  - Required: SR=0000, SR_RISE=0000, STUCK=0000 after that edge.
  - After RESET drops, SR=1111 after the full 2+4 latency.
- Simultaneous arrival: RAW[1] and RAW[2] rise on the same cycle.
  - Required: SR[1] and SR[2], and SR_RISE[1] and SR_RISE[2], assert on the identical edge.
